// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding, fixed latencies and Booth digit encoding for iter_multdiv
package multdiv_pkg;
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    localparam int MUL_LATENCY = 17;
    localparam int DIV_LATENCY = 33;
    typedef enum logic [2:0] {BZERO, BPOS1, BPOS2, BNEG1, BNEG2} booth_t;
    function automatic booth_t boothDigit(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return BPOS1;
            3'b011:         return BPOS2;
            3'b100:         return BNEG2;
            3'b101, 3'b110: return BNEG1;
            default:        return BZERO;
        endcase
    endfunction
endpackage

// File: rtl/booth_r4_select.sv
// booth_r4_select: radix-4 Booth partial product (0, +-A, +-2A) sign-extended to WIDTH+2 bits
module booth_r4_select
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH+1:0] partial
);
    booth_t digit;
    logic [WIDTH+1:0] aExt, a2;
    always_comb begin
        digit = boothDigit(bits);
        aExt = {{2{a[WIDTH-1]}}, a};
        a2 = {a[WIDTH-1], a, 1'b0};
        partial = digit == BPOS1 ? aExt :
                  digit == BPOS2 ? a2 :
                  digit == BNEG1 ? -aExt :
                  digit == BNEG2 ? -a2 : '0;
    end
endmodule

// File: rtl/iter_multdiv.sv
// iter_multdiv: fixed-latency signed multiply (radix-4 Booth) / divide (non-restoring) unit
module iter_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int MUL_ITERS = WIDTH / 2;
    localparam int DIV_ITERS = WIDTH;
    localparam int CW = $clog2(DIV_ITERS) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_ITERS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITERS - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, nextState;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] opA, opB, lo, quo, divisor, absA, absB, quoFinal;
    logic [WIDTH+1:0] hi, partial, hiSum;
    logic [WIDTH:0] rem, remShift, remNext, prodTop;
    logic guard, isMul, negQ, start;

    assign start = (state == IDLE || state == DONE) && (ctrl_MULT || ctrl_DIV);
    assign data_resultRDY = state == DONE;

    booth_r4_select #(.WIDTH(WIDTH)) uBooth (
        .bits({lo[1:0], guard}),
        .a(opA),
        .partial(partial)
    );

    always_comb begin
        hiSum = hi + partial;
        remShift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        remNext = rem[WIDTH] ? remShift + {1'b0, divisor} : remShift - {1'b0, divisor};
        absA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        absB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        quoFinal = negQ ? -quo : quo;
        // Product bits [2W-1:W-1]; all-equal means it fits in WIDTH signed bits
        prodTop = {hi[WIDTH-1:0], lo[WIDTH-1]};
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: nextState = start ? (ctrl_MULT ? MUL : DIV) : IDLE;
            MUL:        nextState = count == MUL_LAST ? FIX : MUL;
            DIV:        nextState = count == DIV_LAST ? FIX : DIV;
            FIX:        nextState = DONE;
            default:    nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            data_result <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            opA <= data_operandA;
            opB <= data_operandB;
            count <= '0;
            isMul <= ctrl_MULT;
            hi <= '0;
            lo <= data_operandB;
            guard <= 1'b0;
            quo <= absA;
            divisor <= absB;
            rem <= '0;
            negQ <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end else if (state == MUL) begin
            hi <= {{2{hiSum[WIDTH+1]}}, hiSum[WIDTH+1:2]};
            lo <= {hiSum[1:0], lo[WIDTH-1:2]};
            guard <= lo[1];
            count <= count + 1'b1;
        end else if (state == DIV) begin
            rem <= remNext;
            quo <= {quo[WIDTH-2:0], ~remNext[WIDTH]};
            count <= count + 1'b1;
        end else if (state == FIX) begin
            if (isMul) begin
                data_result <= lo;
                data_exception <= !(&prodTop || ~|prodTop);
            end else begin
                rem <= rem[WIDTH] ? rem + {1'b0, divisor} : rem;
                data_result <= opB == '0 ? '0 : quoFinal;
                data_exception <= opB == '0 || (opA == MOST_NEG && &opB);
            end
        end
    end
endmodule

// File: tb/tb_iter_multdiv.sv
// tb_iter_multdiv: scoreboard bench for iter_multdiv covering latency, results, exceptions and control corner cases
module tb_iter_multdiv;
    import multdiv_pkg::*;

    logic clock = 0, reset = 1, mult = 0, div = 0;
    logic [31:0] a = 0, b = 0, result;
    logic exc, rdy;
    int checks = 0, failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    iter_multdiv #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(a),
        .data_operandB(b),
        .ctrl_MULT(mult),
        .ctrl_DIV(div),
        .data_result(result),
        .data_exception(exc),
        .data_resultRDY(rdy)
    );

    always #5 clock = ~clock;

    task automatic startOp(input logic isMul, input logic [31:0] x, y, er, input logic ee);
        a = x;
        b = y;
        mult = isMul;
        div = !isMul;
        sb.push_back('{er, ee, isMul ? MUL_LATENCY : DIV_LATENCY});
        @(posedge clock); #1;
        mult = 0;
        div = 0;
    endtask

    task automatic waitRdy(output int n);
        n = 1;
        @(posedge clock); #1;
        while (!rdy && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({result, exc, rdy} !== 34'b0) begin
            failures++;
            $display("FAIL reset_state got res=%h exc=%b rdy=%b want 0/0/0", result, exc, rdy);
        end
        reset = 0;
    endtask

    task automatic test_mult;
        logic [31:0] ta[4] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [31:0] tb[4] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'hFFFF_FFFA};
        logic [31:0] tr[4] = '{32'hFFFF_FFEB, 32'h0, 32'h8000_0000, 32'd30};
        logic te[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int n;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            startOp(1, ta[i], tb[i], tr[i], te[i]);
            waitRdy(n);
            e = sb.pop_front();
            checks++;
            if (n !== e.lat) begin
                failures++;
                $display("FAIL mult_latency[%0d] got %0d want %0d", i, n, e.lat);
            end
            checks++;
            if ({result, exc} !== {e.res, e.exc}) begin
                failures++;
                $display("FAIL mult_result[%0d] got %h/%b want %h/%b", i, result, exc, e.res, e.exc);
            end
            @(posedge clock); #1;
            checks++;
            if (rdy !== 1'b0) begin
                failures++;
                $display("FAIL mult_rdy_width[%0d] got rdy=%b want 0", i, rdy);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] ta[5] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb[5] = '{32'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'h10};
        logic [31:0] tr[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'h0, 32'h8000_0000, 32'h07FF_FFFF};
        logic te[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int n;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            startOp(0, ta[i], tb[i], tr[i], te[i]);
            waitRdy(n);
            e = sb.pop_front();
            checks++;
            if (n !== e.lat) begin
                failures++;
                $display("FAIL div_latency[%0d] got %0d want %0d", i, n, e.lat);
            end
            checks++;
            if ({result, exc} !== {e.res, e.exc}) begin
                failures++;
                $display("FAIL div_result[%0d] got %h/%b want %h/%b", i, result, exc, e.res, e.exc);
            end
            @(posedge clock); #1;
            checks++;
            if (rdy !== 1'b0) begin
                failures++;
                $display("FAIL div_rdy_width[%0d] got rdy=%b want 0", i, rdy);
            end
        end
    endtask

    task automatic test_ignore;
        int n = 1;
        exp_t e;
        startOp(1, 32'd9, 32'd11, 32'd99, 1'b0);
        @(posedge clock); #1;
        while (!rdy && n < 100) begin
            if (n == 4) begin
                a = 32'd50;
                b = 32'd5;
                div = 1;
            end
            if (n == 5) div = 0;
            @(posedge clock); #1;
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) begin
            failures++;
            $display("FAIL ignore_latency got %0d want %0d", n, e.lat);
        end
        checks++;
        if ({result, exc} !== {e.res, e.exc}) begin
            failures++;
            $display("FAIL ignore_result got %h/%b want %h/%b", result, exc, e.res, e.exc);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_priority;
        int n;
        exp_t e;
        a = 32'd6;
        b = 32'd7;
        mult = 1;
        div = 1;
        sb.push_back('{32'd42, 1'b0, MUL_LATENCY});
        @(posedge clock); #1;
        mult = 0;
        div = 0;
        waitRdy(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) begin
            failures++;
            $display("FAIL priority_latency got %0d want %0d", n, e.lat);
        end
        checks++;
        if ({result, exc} !== {e.res, e.exc}) begin
            failures++;
            $display("FAIL priority_result got %h/%b want %h/%b", result, exc, e.res, e.exc);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_abort;
        int n;
        int seen = 0;
        exp_t e;
        startOp(0, 32'd77, 32'd3, 32'd25, 1'b0);
        void'(sb.pop_front());
        repeat (5) @(posedge clock);
        #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        checks++;
        if ({result, exc, rdy} !== 34'b0) begin
            failures++;
            $display("FAIL abort_outputs got res=%h exc=%b rdy=%b want 0/0/0", result, exc, rdy);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (rdy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_rdy got %0d pulses want 0", seen);
        end
        startOp(1, 32'd3, 32'd4, 32'd12, 1'b0);
        waitRdy(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat || {result, exc} !== {e.res, e.exc}) begin
            failures++;
            $display("FAIL abort_recover got lat=%0d %h/%b want lat=%0d %h/%b", n, result, exc, e.lat, e.res, e.exc);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        exp_t e;
        startOp(1, 32'd3, 32'd4, 32'd12, 1'b0);
        waitRdy(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat || {result, exc} !== {e.res, e.exc}) begin
            failures++;
            $display("FAIL b2b_first got lat=%0d %h/%b want lat=%0d %h/%b", n, result, exc, e.lat, e.res, e.exc);
        end
        startOp(0, 32'd12, 32'd5, 32'd2, 1'b0);
        checks++;
        if (rdy !== 1'b0 || result !== 32'd12) begin
            failures++;
            $display("FAIL b2b_hold got rdy=%b res=%h want 0/%h", rdy, result, 32'd12);
        end
        waitRdy(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) begin
            failures++;
            $display("FAIL b2b_latency got %0d want %0d", n, e.lat);
        end
        checks++;
        if ({result, exc} !== {e.res, e.exc}) begin
            failures++;
            $display("FAIL b2b_second got %h/%b want %h/%b", result, exc, e.res, e.exc);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore();
        test_priority();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
